// File: rtl/fpu_pkg.sv
// Shared single-precision field definitions and pipeline stage records for the int32-to-float32 converter.
// FPU_ITOF_RNE_EN adds guard/sticky to the S2 record for round-to-nearest-even; otherwise truncation.
package fpu_pkg;

  localparam int FP_BIAS  = 127;
  localparam int FP_EXP_W = 8;
  localparam int FP_MAN_W = 23;

  // Exponent of a value whose leading one sits at bit 31.
  localparam logic [FP_EXP_W-1:0] FP_EXP_TOP = FP_EXP_W'(FP_BIAS + 31);

  typedef struct packed {
    logic                sign;
    logic [FP_EXP_W-1:0] exp;
    logic [FP_MAN_W-1:0] man;
  } float32_t;

  typedef struct packed {
    logic        vld;
    logic        sign;
    logic [32:0] mag;
  } s1_t;

  typedef struct packed {
    logic                vld;
    logic                sign;
    logic                zero;
    logic [FP_EXP_W-1:0] exp;
    logic [FP_MAN_W-1:0] man;
`ifdef FPU_ITOF_RNE_EN
    logic                guard;
    logic                sticky;
`endif
  } s2_t;

  function automatic float32_t fp_pack(input logic sign,
                                       input logic [FP_EXP_W-1:0] exp,
                                       input logic [FP_MAN_W-1:0] man);
    float32_t f;
    f.sign = sign;
    f.exp  = exp;
    f.man  = man;
    return f;
  endfunction

endpackage

// File: rtl/itof_pipe_if.sv
// Valid/ready request and result channels of the int32-to-float32 converter.
// master = producer/consumer side, slave = converter side.
interface itof_pipe_if;

  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;

  modport master (
    output in_valid,
    output in_data,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data
  );

endinterface

// File: rtl/lzc32.sv
// Combinational leading-zero counter over 32 bits; returns 32 for an all-zero input.
// No state, no handshake.
module lzc32 (
  input  logic [31:0] din,
  output logic [5:0]  cnt
);

  // Scanning upwards lets the highest set bit win.
  always_comb begin
    cnt = 6'd32;
    for (int i = 0; i < 32; i++) begin
      if (din[i]) begin
        cnt = 6'(31 - i);
      end
    end
  end

endmodule

// File: rtl/itof_pipe.sv
// Signed int32 -> IEEE-754 single, 3 registered stages, latency 3, one result per cycle; a single advance
// enable stalls every stage while the result is held unaccepted. FPU_ITOF_RNE_EN selects RNE, else truncation.
module itof_pipe
  import fpu_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  itof_pipe_if.slave io
);

  logic adv;
  assign adv         = !io.out_valid || io.out_ready;
  assign io.in_ready = adv;

  // ---------------- S1: sign and magnitude ----------------
  s1_t         s1_q;
  logic [32:0] abs_c;

  // 33-bit arithmetic keeps |-2^31| representable.
  always_comb begin
    abs_c = {io.in_data[31], io.in_data};
    if (io.in_data[31]) begin
      abs_c = 33'd0 - {io.in_data[31], io.in_data};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= '0;
    end else if (adv) begin
      s1_q.vld  <= io.in_valid;
      s1_q.sign <= io.in_data[31];
      s1_q.mag  <= abs_c;
    end
  end

  // ---------------- S2: leading-zero count and normalize ----------------
  s2_t        s2_q;
  logic [5:0] lz;

  lzc32 u_lzc (
    .din (s1_q.mag[31:0]),
    .cnt (lz)
  );

  // Only the bits below the leading one are kept; the leading one is implicit.
`ifdef FPU_ITOF_RNE_EN
  logic [30:0] below_c;
  assign below_c = 31'(s1_q.mag[31:0] << lz);
`else
  logic [FP_MAN_W-1:0] below_c;
  assign below_c = FP_MAN_W'((s1_q.mag[31:0] << lz) >> 8);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_q <= '0;
    end else if (adv) begin
      s2_q.vld  <= s1_q.vld;
      s2_q.sign <= s1_q.sign;
      s2_q.zero <= (s1_q.mag == 33'd0);
      s2_q.exp  <= FP_EXP_TOP - {2'b00, lz};
`ifdef FPU_ITOF_RNE_EN
      s2_q.man    <= below_c[30:8];
      s2_q.guard  <= below_c[7];
      s2_q.sticky <= |below_c[6:0];
`else
      s2_q.man    <= below_c;
`endif
    end
  end

  // ---------------- S3: round, exponent adjust, pack ----------------
  logic [FP_EXP_W-1:0] exp_c;
  logic [FP_MAN_W-1:0] man_c;
  float32_t            res_c;

`ifdef FPU_ITOF_RNE_EN
  logic              round_up;
  logic [FP_MAN_W:0] man_sum;

  // A mantissa carry-out leaves the low bits zero, so only the exponent needs bumping.
  always_comb begin
    round_up = s2_q.guard & (s2_q.sticky | s2_q.man[0]);
    man_sum  = {1'b0, s2_q.man} + {{FP_MAN_W{1'b0}}, round_up};
    exp_c    = s2_q.exp + {{(FP_EXP_W-1){1'b0}}, man_sum[FP_MAN_W]};
    man_c    = man_sum[FP_MAN_W-1:0];
  end
`else
  always_comb begin
    exp_c = s2_q.exp;
    man_c = s2_q.man;
  end
`endif

  // Zero always packs as +0.
  always_comb begin
    res_c = '0;
    if (!s2_q.zero) begin
      res_c = fp_pack(s2_q.sign, exp_c, man_c);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      io.out_valid <= 1'b0;
      io.out_data  <= 32'd0;
    end else if (adv) begin
      io.out_valid <= s2_q.vld;
      if (s2_q.vld) begin
        io.out_data <= res_c;
      end
    end
  end

endmodule

// File: tb/tb_itof_pipe.sv
// Self-checking bench for itof_pipe: directed vector table, back-to-back, backpressure, reset-flush and a
// randomized stream against an independent arithmetic reference for the compiled rounding mode.
module tb_itof_pipe;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  itof_pipe_if io ();

  itof_pipe dut (
    .clk (clk),
    .rst (rst),
    .io  (io)
  );

  int checks = 0;
  int errors = 0;

  logic        acc;
  logic        got;
  logic [31:0] got_data;

  typedef struct {
    logic [31:0] din;
    logic [31:0] rne;
    logic [31:0] trn;
  } vec_t;

  localparam int NV = 18;
  localparam int NR = 3000;

  vec_t vecs [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // Drive inputs for this cycle, let combinational paths settle, note which handshakes will fire.
  task automatic drive(input logic iv, input logic [31:0] d, input logic ordy);
    io.in_valid  = iv;
    io.in_data   = d;
    io.out_ready = ordy;
    #1;
    acc      = iv && io.in_ready && !rst;
    got      = io.out_valid && io.out_ready && !rst;
    got_data = io.out_data;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Single transfer; lat counts cycles from accept to the result (-1 on timeout).
  task automatic run_one(input logic [31:0] d, output logic [31:0] res, output int lat);
    int n;
    res = 32'd0;
    lat = -1;
    n   = 0;
    drive(1'b1, d, 1'b1);
    while (!acc && n < 20) begin
      tick;
      n++;
      drive(1'b1, d, 1'b1);
    end
    if (!acc) return;
    tick;
    for (int c = 1; c <= 20; c++) begin
      drive(1'b0, 32'd0, 1'b1);
      if (got) begin
        res = got_data;
        lat = c;
        tick;
        return;
      end
      tick;
    end
  endtask

  function automatic logic [31:0] ref_itof(input logic [31:0] x);
    logic        s;
    logic [63:0] m;
    logic [63:0] q;
    int          e;
    int          sh;
    s = x[31];
    m = {32'd0, (s ? (~x + 32'd1) : x)};
    if (m == 64'd0) return 32'd0;
    e = 0;
    for (int i = 0; i < 32; i++) if (m[i]) e = i;
    if (e <= 23) begin
      q = m << (23 - e);
    end else begin
      sh = e - 23;
      q  = m >> sh;
`ifdef FPU_ITOF_RNE_EN
      begin : rnd
        logic [63:0] rem;
        logic [63:0] half;
        rem  = m & ((64'd1 << sh) - 64'd1);
        half = 64'd1 << (sh - 1);
        if (rem > half || (rem == half && q[0])) q = q + 64'd1;
      end
`endif
      if (q == 64'h1000000) begin
        q = q >> 1;
        e = e + 1;
      end
    end
    return {s, 8'(e + 127), q[22:0]};
  endfunction

  function automatic logic [31:0] rnd_val();
    logic [31:0] v;
    case ($urandom_range(0, 3))
      0: v = $urandom;
      1: v = $urandom_range(0, 32'h01FFFFFF) - 32'h01000000;
      2: begin
        case ($urandom_range(0, 4))
          0: v = 32'h00000000;
          1: v = 32'h00000001;
          2: v = 32'hFFFFFFFF;
          3: v = 32'h80000000;
          default: v = 32'h7FFFFFFF;
        endcase
      end
      default: begin
        v = $urandom >> $urandom_range(0, 31);
        if ($urandom_range(0, 1) == 1) v = ~v + 32'd1;
      end
    endcase
    return v;
  endfunction

  initial begin
    logic [31:0] seq_in  [3];
    logic [31:0] seq_exp [3];
    logic [31:0] bp_in   [5];
    logic [31:0] bp_exp  [5];
    logic [31:0] res;
    logic [31:0] expv;
    logic [31:0] held;
    logic [31:0] cur;
    logic [31:0] dv;
    logic [31:0] expq [$];
    int          lat;
    int          idx;
    int          nrx;
    int          stall;
    int          extra;
    int          sent;
    int          rcvd;
    int          cyc;
    bit          stalled;
    logic        iv;

    vecs = '{
      '{32'h00000001, 32'h3F800000, 32'h3F800000},
      '{32'hFFFFFFFF, 32'hBF800000, 32'hBF800000},
      '{32'h00000000, 32'h00000000, 32'h00000000},
      '{32'h00000002, 32'h40000000, 32'h40000000},
      '{32'h00000003, 32'h40400000, 32'h40400000},
      '{32'hFFFFFFFB, 32'hC0A00000, 32'hC0A00000},
      '{32'h00000064, 32'h42C80000, 32'h42C80000},
      '{32'h40000000, 32'h4E800000, 32'h4E800000},
      '{32'h80000000, 32'hCF000000, 32'hCF000000},
      '{32'h7FFFFFFF, 32'h4F000000, 32'h4EFFFFFF},
      '{32'h01000001, 32'h4B800000, 32'h4B800000},
      '{32'h01000003, 32'h4B800002, 32'h4B800001},
      '{32'hFEFFFFFD, 32'hCB800002, 32'hCB800001},
      '{32'h00FFFFFF, 32'h4B7FFFFF, 32'h4B7FFFFF},
      '{32'hFF000001, 32'hCB7FFFFF, 32'hCB7FFFFF},
      '{32'h02000002, 32'h4C000000, 32'h4C000000},
      '{32'h02000006, 32'h4C000002, 32'h4C000001},
      '{32'h02000003, 32'h4C000001, 32'h4C000000}
    };
    seq_in  = '{32'h00000001, 32'hFFFFFFFF, 32'h00000000};
    seq_exp = '{32'h3F800000, 32'hBF800000, 32'h00000000};
    bp_in   = '{32'd10, 32'd20, 32'd30, 32'd40, 32'd50};
    bp_exp  = '{32'h41200000, 32'h41A00000, 32'h41F00000, 32'h42200000, 32'h42480000};

    io.in_valid  = 1'b0;
    io.in_data   = 32'd0;
    io.out_ready = 1'b0;
    rst          = 1'b1;
    tick;
    tick;
    rst = 1'b0;

    // Reset state, with out_ready low so in_ready reflects out_valid alone.
    drive(1'b0, 32'd0, 1'b0);
    chk("reset_out_valid", {31'd0, io.out_valid}, 32'd0);
    chk("reset_out_data", io.out_data, 32'd0);
    chk("reset_in_ready", {31'd0, io.in_ready}, 32'd1);
    tick;

    // Back-to-back 1, -1, 0: results exactly on cycles 3, 4, 5 after the first accept.
    for (int k = 0; k < 8; k++) begin
      dv = 32'd0;
      if (k < 3) dv = seq_in[k];
      drive(k < 3, dv, 1'b1);
      if (k < 3) chk($sformatf("b2b_accept_%0d", k), {31'd0, acc}, 32'd1);
      chk($sformatf("b2b_valid_c%0d", k), {31'd0, got}, {31'd0, (k >= 3 && k <= 5)});
      if (got && k >= 3 && k <= 5) chk($sformatf("b2b_data_c%0d", k), got_data, seq_exp[k-3]);
      tick;
    end

    // Directed vector table.
    for (int i = 0; i < NV; i++) begin
`ifdef FPU_ITOF_RNE_EN
      expv = vecs[i].rne;
`else
      expv = vecs[i].trn;
`endif
      run_one(vecs[i].din, res, lat);
      chk($sformatf("vec_lat_%08h", vecs[i].din), lat, 32'd3);
      chk($sformatf("vec_%08h", vecs[i].din), res, expv);
    end

    // Backpressure: stall 4 cycles at first out_valid while 5 operands stream in.
    idx     = 0;
    nrx     = 0;
    stall   = 0;
    stalled = 1'b0;
    held    = 32'd0;
    for (int c = 0; c < 40 && nrx < 5; c++) begin
      if (!stalled && io.out_valid) begin
        stalled = 1'b1;
        stall   = 4;
        held    = io.out_data;
      end
      dv = 32'd0;
      if (idx < 5) dv = bp_in[idx];
      drive(idx < 5, dv, stall == 0);
      if (stall > 0) begin
        chk("bp_in_ready_low", {31'd0, io.in_ready}, 32'd0);
        chk("bp_out_valid_held", {31'd0, io.out_valid}, 32'd1);
        chk("bp_out_data_held", io.out_data, held);
        stall--;
      end
      if (acc) idx++;
      if (got) begin
        if (nrx < 5) chk($sformatf("bp_result_%0d", nrx), got_data, bp_exp[nrx]);
        nrx++;
      end
      tick;
    end
    chk("bp_stall_seen", {31'd0, stalled}, 32'd1);
    chk("bp_count", nrx, 32'd5);
    extra = 0;
    for (int c = 0; c < 6; c++) begin
      drive(1'b0, 32'd0, 1'b1);
      if (got) extra++;
      tick;
    end
    chk("bp_no_duplicate", extra, 32'd0);

    // Reset with three operands in flight, colliding with both handshakes.
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 32'd7 + 32'(k), 1'b1);
      chk($sformatf("rst_fill_accept_%0d", k), {31'd0, acc}, 32'd1);
      tick;
    end
    rst = 1'b1;
    drive(1'b1, 32'h00012345, 1'b1);
    tick;
    rst = 1'b0;
    drive(1'b0, 32'd0, 1'b0);
    chk("rst_flush_out_valid", {31'd0, io.out_valid}, 32'd0);
    chk("rst_flush_out_data", io.out_data, 32'd0);
    chk("rst_flush_in_ready", {31'd0, io.in_ready}, 32'd1);
    tick;
    extra = 0;
    for (int c = 0; c < 6; c++) begin
      drive(1'b0, 32'd0, 1'b1);
      if (got) extra++;
      tick;
    end
    chk("rst_no_stale", extra, 32'd0);
    run_one(32'd2, res, lat);
    chk("rst_after_lat", lat, 32'd3);
    chk("rst_after_data", res, 32'h40000000);

    // Randomized stream with valid/ready gaps against the reference.
    sent = 0;
    rcvd = 0;
    cyc  = 0;
    cur  = rnd_val();
    while ((sent < NR || rcvd < sent) && cyc < 30000) begin
      iv = (sent < NR) && ($urandom_range(0, 3) != 0);
      drive(iv, cur, $urandom_range(0, 3) != 0);
      if (acc) begin
        expq.push_back(ref_itof(cur));
        sent++;
        cur = rnd_val();
      end
      if (got) begin
        if (expq.size() == 0) begin
          chk("rand_unexpected", got_data, 32'hDEADBEEF);
        end else begin
          expv = expq.pop_front();
          chk("rand", got_data, expv);
        end
        rcvd++;
      end
      tick;
      cyc++;
    end
    chk("rand_count", rcvd, NR);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
